// File: rtl/elbeth_lsu_pkg.sv
// Shared encodings for the ELBETH load/store unit: access sizes, response codes, FSM states.
package elbeth_lsu_pkg;

    typedef logic [1:0] lsu_size_t;

    localparam lsu_size_t LSU_BYTE = 2'b00;
    localparam lsu_size_t LSU_HALF = 2'b01;
    localparam lsu_size_t LSU_WORD = 2'b10;

    localparam logic [1:0] LSU_OK       = 2'b00;
    localparam logic [1:0] LSU_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_TIMEOUT  = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_WAIT   = 2'b10;

endpackage

// File: rtl/elbeth_lsu_align.sv
// Combinational lane logic: misalignment check, store strobes/replication, load select and extension.
module elbeth_lsu_align
    import elbeth_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  lsu_size_t   st_size,
    input  logic [31:0] st_wdata,
    output logic        misaligned,
    output logic [3:0]  st_rw,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_off,
    input  lsu_size_t   ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        misaligned = 1'b0;
        st_rw      = 4'b1111;
        st_data    = st_wdata;
        case (st_size)
            LSU_BYTE: begin
                st_rw   = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            LSU_HALF: begin
                misaligned = st_off[0];
                st_rw      = 4'b0011 << st_off;
                st_data    = {2{st_wdata[15:0]}};
            end
            default: misaligned = (st_off != 2'b00);
        endcase
    end

    always_comb begin
        ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (ld_size)
            LSU_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            LSU_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default:  ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/elbeth_lsu.sv
// ELBETH load/store unit: one request at a time onto a single memory port.
// Build option ELBETH_LSU_TIMEOUT_EN adds a WAIT-state watchdog that answers with a timeout error.
//   state     | meaning
//   ST_IDLE   | ready for a request; misaligned requests are answered from here
//   ST_ACCESS | single cycle with mem_enable high
//   ST_WAIT   | waiting for mem_ready
module elbeth_lsu
    import elbeth_lsu_pkg::*;
#(
    parameter int AW      = 14,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic          req_we,
    input  lsu_size_t     req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data_in,
    output logic [3:0]    mem_rw,
    input  logic [31:0]   mem_data_out,
    input  logic          mem_ready
);
    logic [1:0]    state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic          mem_enable_q, mem_enable_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_in_q, mem_data_in_d;
    logic [3:0]    mem_rw_q, mem_rw_d;
    logic [1:0]    ld_off_q, ld_off_d;
    lsu_size_t     ld_size_q, ld_size_d;
    logic          ld_uns_q, ld_uns_d;
    logic          we_q, we_d;

    logic          misaligned;
    logic [3:0]    st_rw;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;

    // Upper address bits wrap silently onto the word address.
    logic          addr_hi_unused;
    assign addr_hi_unused = ^req_addr[31:AW+2];

`ifdef ELBETH_LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
`else
    logic [31:0]   timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    elbeth_lsu_align u_align (
        .st_off      (req_addr[1:0]),
        .st_size     (req_size),
        .st_wdata    (req_wdata),
        .misaligned  (misaligned),
        .st_rw       (st_rw),
        .st_data     (st_data),
        .ld_off      (ld_off_q),
        .ld_size     (ld_size_q),
        .ld_unsigned (ld_uns_q),
        .ld_raw      (mem_data_out),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_enable_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_rw_d      = 4'b0000;
        ld_off_d      = ld_off_q;
        ld_size_d     = ld_size_q;
        ld_uns_d      = ld_uns_q;
        we_d          = we_q;
`ifdef ELBETH_LSU_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    ld_off_d  = req_addr[1:0];
                    ld_size_d = req_size;
                    ld_uns_d  = req_unsigned;
                    we_d      = req_we;
                    if (misaligned) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = LSU_MISALIGN;
                    end else begin
                        state_d       = ST_ACCESS;
                        req_ready_d   = 1'b0;
                        mem_enable_d  = 1'b1;
                        mem_addr_d    = req_addr[AW+1:2];
                        mem_data_in_d = st_data;
                        mem_rw_d      = req_we ? st_rw : 4'b0000;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
`ifdef ELBETH_LSU_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = LSU_OK;
                    rsp_rdata_d = we_q ? '0 : ld_data;
                end
`ifdef ELBETH_LSU_TIMEOUT_EN
                // This cycle is the TIMEOUT-th WAIT cycle without mem_ready.
                else if (to_cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = LSU_TIMEOUT;
                    rsp_rdata_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= LSU_OK;
            mem_enable_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_rw_q      <= 4'b0000;
            ld_off_q      <= 2'b00;
            ld_size_q     <= LSU_BYTE;
            ld_uns_q      <= 1'b0;
            we_q          <= 1'b0;
`ifdef ELBETH_LSU_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_enable_q  <= mem_enable_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_rw_q      <= mem_rw_d;
            ld_off_q      <= ld_off_d;
            ld_size_q     <= ld_size_d;
            ld_uns_q      <= ld_uns_d;
            we_q          <= we_d;
`ifdef ELBETH_LSU_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_enable  = mem_enable_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_rw      = mem_rw_q;

endmodule

// File: tb/tb_elbeth_lsu.sv
// Scoreboard bench for elbeth_lsu against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_elbeth_lsu;
    localparam int AW      = 14;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_err;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic [3:0]    mem_rw;
    logic [31:0]   mem_data_out = 32'h0;
    logic          mem_ready = 1'b0;

    elbeth_lsu #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_enable   (mem_enable),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_rw       (mem_rw),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic [1:0] err; int lat; int acc; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic [3:0] rw; logic [31:0] data; } mtx_t;
    rsp_t       exp_rsp[$];
    mtx_t       exp_mem[$];
    int         lat_q[$];
    logic [7:0] ref_mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory port model: registered read, byte-strobed write, ready after a per-access delay.
    logic [31:0] mem_arr [int];
    logic        stall = 1'b0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;
    logic [31:0] mold, mw;
    int          ml;

    always @(posedge clk) begin
        mem_ready    <= 1'b0;
        mem_data_out <= $urandom;
        if (!rst) begin
            pend <= 1'b0;
        end else if (mem_enable) begin
            ml   = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            mold = mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)] : 32'h0;
            mw   = mold;
            for (int i = 0; i < 4; i++)
                if (mem_rw[i]) mw[8*i +: 8] = mem_data_in[8*i +: 8];
            mem_arr[int'(mem_addr)] = mw;
            if (ml == 0 && !stall) begin
                mem_ready    <= 1'b1;
                mem_data_out <= mold;
            end else begin
                pend      <= 1'b1;
                pend_cnt  <= (ml == 0) ? 0 : ml - 1;
                pend_data <= mold;
            end
        end else if (pend && !stall) begin
            if (pend_cnt == 0) begin
                mem_ready    <= 1'b1;
                mem_data_out <= pend_data;
                pend         <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // Monitor: compares every memory strobe and every response against the queues.
    mtx_t mon_m;
    rsp_t mon_r;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_en = 1'b0;
        end else begin
            if (mem_enable) begin
                if (prev_en) begin
                    checks++; errors++;
                    $display("FAIL mem_enable_pulse: high in two consecutive cycles at cycle %0d", cyc);
                end
                if (exp_mem.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access: mem_enable=1 addr %h, expected no access", mem_addr);
                end else begin
                    mon_m = exp_mem.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
                    chk("mem_rw", 32'(mem_rw), 32'(mon_m.rw));
                    if (mon_m.rw != 4'b0000) chk("mem_data_in", mem_data_in, mon_m.data);
                end
            end
            prev_en = mem_enable;
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 err %b rdata %h, expected none", rsp_err, rsp_rdata);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                    if (mon_r.lat >= 0) chk("rsp_latency", 32'(cyc - mon_r.acc), 32'(mon_r.lat));
                end
            end
        end
    end

    // Issue one request; expectations come from the byte-addressed reference memory.
    task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input int lat);
        rsp_t        r;
        mtx_t        m;
        int          n, base, w, acc;
        logic [31:0] v;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(a[15:0]);
        r.rdata = 32'h0;
        r.err   = 2'b00;
        r.lat   = 3 + lat;
        r.acc   = 0;
        if ((a & 32'(n - 1)) != 32'h0) begin
            r.err = 2'b01;
            r.lat = 1;
        end else begin
            m.addr = a[AW+1:2];
            m.rw   = 4'b0000;
            m.data = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    ref_mem[base + i] = wd[8*i +: 8];
                    m.rw[(base + i) & 3] = 1'b1;
                end
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++)
                    v[8*i +: 8] = ref_mem.exists(base + i) ? ref_mem[base + i] : 8'h00;
                if (!uns && v[8*n-1])
                    for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                r.rdata = v;
            end
            if (stall) begin
`ifdef ELBETH_LSU_TIMEOUT_EN
                r.rdata = 32'h0;
                r.err   = 2'b10;
                r.lat   = 2 + TIMEOUT;
`else
                r.lat   = -1;
`endif
            end
            exp_mem.push_back(m);
            lat_q.push_back(lat);
        end
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        w = 0;
        while (!req_ready) begin
            @(negedge clk);
            w++;
            if (w > 200) begin
                $display("FAIL req_accept: req_ready stayed 0 for %0d cycles, expected 1", w);
                $fatal(1, "request never accepted");
            end
        end
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        r.acc = acc;
        exp_rsp.push_back(r);
    endtask

    task automatic drain(input int maxc);
        int w;
        w = 0;
        while ((exp_rsp.size() != 0 || exp_mem.size() != 0) && w < maxc) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (exp_rsp.size() != 0 || exp_mem.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses and %0d accesses outstanding after %0d cycles, expected 0",
                     exp_rsp.size(), exp_mem.size(), w);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic [31:0] a;
        req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_mem_enable", 32'(mem_enable), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_rw", 32'(mem_rw), 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        rst = 1'b1;

        issue(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 0);
        issue(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        issue(32'h13, 1'b1, 2'b00, 1'b0, 32'h123456A5, 0);
        issue(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 0);
        issue(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 0);
        issue(32'h10, 1'b1, 2'b10, 1'b0, 32'h80011234, 0);
        issue(32'h12, 1'b0, 2'b01, 1'b0, 32'h0, 0);
        issue(32'h12, 1'b0, 2'b01, 1'b1, 32'h0, 0);
        issue(32'h11, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 0);
        issue(32'h02, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        issue(32'h06, 1'b1, 2'b01, 1'b0, 32'h0000CAFE, 1);
        issue(32'hFFFF0010, 1'b0, 2'b11, 1'b0, 32'h0, 2);
        issue(32'h07, 1'b0, 2'b00, 1'b0, 32'h0, 0);
        drain(50);

        issue(32'h20, 1'b0, 2'b10, 1'b0, 32'h5A5A5A5A, 0);
        chk("access_before_reset", 32'(mem_enable), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("arst_mem_enable", 32'(mem_enable), 32'h0);
        chk("arst_mem_addr", 32'(mem_addr), 32'h0);
        chk("arst_mem_rw", 32'(mem_rw), 32'h0);
        chk("arst_mem_data_in", mem_data_in, 32'h0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h1);
        exp_rsp.delete(); exp_mem.delete(); lat_q.delete();
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
        end
        chk("post_reset_idle", 32'(ok), 32'h1);

        stall = 1'b1;
        issue(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 0);
`ifdef ELBETH_LSU_TIMEOUT_EN
        drain(40);
        stall = 1'b0;
        repeat (6) @(negedge clk);
`else
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (req_ready !== 1'b0) ok = 1'b0;
        end
        chk("wait_holds_busy", 32'(ok), 32'h1);
        stall = 1'b0;
        drain(20);
`endif

        for (int k = 0; k < 300; k++) begin
            a = {16'($urandom), 10'd0, 6'($urandom)};
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2));
        end
        drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
